// File: rtl/video_stream_ctrl.sv
// Frame sequencer: scans one visible frame per frame_sync, requests RGB444 pixels
// from the colour generator and streams them as RGB888 AXI4-Stream beats with tuser/tlast.

package video_stream_ctrl_pkg;

    typedef struct packed {
        logic        tuser;
        logic        tlast;
        logic [23:0] tdata;
    } beat_t;

endpackage

module video_stream_ctrl
    import video_stream_ctrl_pkg::*;
#(
    parameter int unsigned H_VISIBLE = 640,
    parameter int unsigned V_VISIBLE = 480
) (
    input  logic        pixel_clk,
    input  logic        reset_n,
    input  logic        enable,
    input  logic        frame_sync,
    output logic        req_valid,
    output logic [9:0]  req_x,
    output logic [9:0]  req_y,
    input  logic [11:0] pix_rgb,
    output logic [23:0] m_tdata,
    output logic        m_tvalid,
    output logic        m_tuser,
    output logic        m_tlast,
    input  logic        m_tready,
    output logic        busy,
    output logic        frame_done,
    output logic [15:0] frame_count,
    output logic        sync_miss
);

    localparam int unsigned CW      = 10;
    localparam int unsigned OCC_W   = 3;
    localparam int unsigned SKID_W  = 2;
    localparam int unsigned FC_W    = 16;
    // Output register plus a two-entry skid: three beats of storage in total.
    localparam int unsigned STORE   = 3;
    localparam logic [CW-1:0] X_LAST = CW'(H_VISIBLE - 1);
    localparam logic [CW-1:0] Y_LAST = CW'(V_VISIBLE - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT_SOF,
        S_ACTIVE,
        S_DRAIN
    } state_e;

    state_e              state_q, state_d;
    logic [CW-1:0]       nx_q, nx_d, ny_q, ny_d;
    logic                req_valid_q, req_valid_d;
    logic [CW-1:0]       req_x_q, req_x_d, req_y_q, req_y_d;
    logic                req_user_q, req_user_d, req_last_q, req_last_d;
    logic                pend_q, pend_user_q, pend_last_q;
    beat_t               out_q, out_d;
    logic                out_valid_q, out_valid_d;
    beat_t               sk0_q, sk0_d, sk1_q, sk1_d;
    logic [SKID_W-1:0]   sk_cnt_q, sk_cnt_d;
    logic                frame_done_q, frame_done_d;
    logic [FC_W-1:0]     frame_count_q, frame_count_d;
    logic                sync_miss_q, sync_miss_d;
    logic                busy_q, busy_d;

    logic                pop_c, start_c, issue_c, last_c, done_c, credit_c;
    logic [OCC_W-1:0]    occ_c;
    logic [CW-1:0]       bx_c, by_c;
    beat_t               new_beat_c;
    logic                skid_pop_c, skid_push_c;
    logic [SKID_W-1:0]   sk_tmp_c;

    function automatic logic [23:0] expand_rgb(input logic [11:0] c);
        return {c[11:8], c[11:8], c[7:4], c[7:4], c[3:0], c[3:0]};
    endfunction

    // Sequencing, credit, coordinate scan and skid-buffer next state.
    always_comb begin
        state_d       = state_q;
        nx_d          = nx_q;
        ny_d          = ny_q;
        req_x_d       = req_x_q;
        req_y_d       = req_y_q;
        req_user_d    = req_user_q;
        req_last_d    = req_last_q;
        out_d         = out_q;
        out_valid_d   = out_valid_q;
        sk0_d         = sk0_q;
        sk1_d         = sk1_q;
        sk_cnt_d      = sk_cnt_q;
        start_c       = 1'b0;
        done_c        = 1'b0;
        skid_pop_c    = 1'b0;
        skid_push_c   = 1'b0;
        sk_tmp_c      = sk_cnt_q;

        pop_c    = out_valid_q & m_tready;
        occ_c    = OCC_W'(out_valid_q) + OCC_W'(sk_cnt_q) + OCC_W'(req_valid_q) + OCC_W'(pend_q);
        // Everything requested must still fit even if no further beat is accepted.
        credit_c = (occ_c - OCC_W'(pop_c)) < OCC_W'(STORE);

        if (state_q == S_WAIT_SOF && enable && frame_sync) begin
            start_c = 1'b1;
        end
        bx_c    = start_c ? '0 : nx_q;
        by_c    = start_c ? '0 : ny_q;
        issue_c = (start_c || state_q == S_ACTIVE) && credit_c;
        last_c  = issue_c && (bx_c == X_LAST) && (by_c == Y_LAST);

        if (issue_c) begin
            req_x_d    = bx_c;
            req_y_d    = by_c;
            req_user_d = (bx_c == '0) && (by_c == '0);
            req_last_d = (bx_c == X_LAST);
            if (bx_c == X_LAST) begin
                nx_d = '0;
                ny_d = (by_c == Y_LAST) ? '0 : by_c + CW'(1);
            end else begin
                nx_d = bx_c + CW'(1);
                ny_d = by_c;
            end
        end

        case (state_q)
            S_IDLE: begin
                if (enable) state_d = S_WAIT_SOF;
            end
            S_WAIT_SOF: begin
                if (!enable)      state_d = S_IDLE;
                else if (start_c) state_d = last_c ? S_DRAIN : S_ACTIVE;
            end
            S_ACTIVE: begin
                if (last_c) state_d = S_DRAIN;
            end
            S_DRAIN: begin
                // Done on the edge that retires the last beat.
                done_c = !req_valid_q && !pend_q && (sk_cnt_q == '0) && (!out_valid_q || pop_c);
                if (done_c) state_d = enable ? S_WAIT_SOF : S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        new_beat_c = '{tuser: pend_user_q, tlast: pend_last_q, tdata: expand_rgb(pix_rgb)};

        if (!out_valid_q || pop_c) begin
            if (sk_cnt_q != '0) begin
                out_d       = sk0_q;
                out_valid_d = 1'b1;
                skid_pop_c  = 1'b1;
                skid_push_c = pend_q;
            end else if (pend_q) begin
                out_d       = new_beat_c;
                out_valid_d = 1'b1;
            end else begin
                out_valid_d = 1'b0;
            end
        end else begin
            skid_push_c = pend_q;
        end

        if (skid_pop_c) begin
            sk0_d    = sk1_q;
            sk_tmp_c = sk_cnt_q - SKID_W'(1);
        end
        if (skid_push_c) begin
            if (sk_tmp_c == '0) sk0_d = new_beat_c;
            else                sk1_d = new_beat_c;
        end
        sk_cnt_d = sk_tmp_c + SKID_W'(skid_push_c);

        req_valid_d   = issue_c;
        frame_done_d  = done_c;
        frame_count_d = frame_count_q + FC_W'(done_c);
        // A sync coinciding with frame completion is not a miss.
        sync_miss_d   = sync_miss_q |
                        (frame_sync && (state_q == S_ACTIVE || state_q == S_DRAIN) && !done_c);
        busy_d        = (state_d == S_ACTIVE) || (state_d == S_DRAIN);
    end

    always_ff @(posedge pixel_clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= S_IDLE;
            nx_q          <= '0;
            ny_q          <= '0;
            req_valid_q   <= 1'b0;
            req_x_q       <= '0;
            req_y_q       <= '0;
            req_user_q    <= 1'b0;
            req_last_q    <= 1'b0;
            pend_q        <= 1'b0;
            pend_user_q   <= 1'b0;
            pend_last_q   <= 1'b0;
            out_q         <= '0;
            out_valid_q   <= 1'b0;
            sk0_q         <= '0;
            sk1_q         <= '0;
            sk_cnt_q      <= '0;
            frame_done_q  <= 1'b0;
            frame_count_q <= '0;
            sync_miss_q   <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            nx_q          <= nx_d;
            ny_q          <= ny_d;
            req_valid_q   <= req_valid_d;
            req_x_q       <= req_x_d;
            req_y_q       <= req_y_d;
            req_user_q    <= req_user_d;
            req_last_q    <= req_last_d;
            pend_q        <= req_valid_q;
            pend_user_q   <= req_user_q;
            pend_last_q   <= req_last_q;
            out_q         <= out_d;
            out_valid_q   <= out_valid_d;
            sk0_q         <= sk0_d;
            sk1_q         <= sk1_d;
            sk_cnt_q      <= sk_cnt_d;
            frame_done_q  <= frame_done_d;
            frame_count_q <= frame_count_d;
            sync_miss_q   <= sync_miss_d;
            busy_q        <= busy_d;
        end
    end

    assign req_valid   = req_valid_q;
    assign req_x       = req_x_q;
    assign req_y       = req_y_q;
    assign m_tdata     = out_q.tdata;
    assign m_tuser     = out_q.tuser;
    assign m_tlast     = out_q.tlast;
    assign m_tvalid    = out_valid_q;
    assign busy        = busy_q;
    assign frame_done  = frame_done_q;
    assign frame_count = frame_count_q;
    assign sync_miss   = sync_miss_q;

endmodule

// File: tb/tb_video_stream_ctrl.sv
// Randomised bench for video_stream_ctrl: raster-order reference model of the
// expected request/beat sequence, checked at the falling clock edge.

module tb_video_stream_ctrl;

    localparam int unsigned H = 8;
    localparam int unsigned V = 4;
    localparam int unsigned N = H * V;

    logic        pixel_clk = 1'b0;
    logic        reset_n   = 1'b1;
    logic        enable    = 1'b0;
    logic        frame_sync = 1'b0;
    logic        req_valid;
    logic [9:0]  req_x, req_y;
    logic [11:0] pix_rgb = '0;
    logic [23:0] m_tdata;
    logic        m_tvalid, m_tuser, m_tlast;
    logic        m_tready = 1'b1;
    logic        busy, frame_done, sync_miss;
    logic [15:0] frame_count;

    int n_checks = 0;
    int n_errors = 0;
    int ready_mode = 0;

    video_stream_ctrl #(.H_VISIBLE(H), .V_VISIBLE(V)) dut (
        .pixel_clk  (pixel_clk),
        .reset_n    (reset_n),
        .enable     (enable),
        .frame_sync (frame_sync),
        .req_valid  (req_valid),
        .req_x      (req_x),
        .req_y      (req_y),
        .pix_rgb    (pix_rgb),
        .m_tdata    (m_tdata),
        .m_tvalid   (m_tvalid),
        .m_tuser    (m_tuser),
        .m_tlast    (m_tlast),
        .m_tready   (m_tready),
        .busy       (busy),
        .frame_done (frame_done),
        .frame_count(frame_count),
        .sync_miss  (sync_miss)
    );

    always #5 pixel_clk = ~pixel_clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Colour generator: fixed one-cycle latency, junk when not requested.
    always @(posedge pixel_clk) begin
        if (req_valid) pix_rgb <= {req_x[3:0], req_y[3:0], 4'hA};
        else           pix_rgb <= 12'($urandom);
    end

    always @(posedge pixel_clk) begin
        #1;
        case (ready_mode)
            0:       m_tready = 1'b1;
            1:       m_tready = 1'($urandom_range(0, 1));
            default: m_tready = 1'b0;
        endcase
    end

    // Reference model: requests and beats both follow raster order, frame after frame.
    int ex_x = 0, ex_y = 0, bidx = 0, fb = 0, beats_total = 0, reqs_total = 0;
    int xb, yb;
    logic        prev_stall = 1'b0;
    logic [25:0] held = '0;

    always @(negedge pixel_clk) begin
        if (!reset_n) begin
            ex_x = 0; ex_y = 0; bidx = 0; fb = 0; prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                check_val("stall_valid", 32'(m_tvalid), 32'd1);
                check_val("stall_payload", 32'({m_tuser, m_tlast, m_tdata}), 32'(held));
            end
            prev_stall = m_tvalid && !m_tready;
            held = {m_tuser, m_tlast, m_tdata};
            if (req_valid) begin
                check_val("req_x", 32'(req_x), 32'(ex_x));
                check_val("req_y", 32'(req_y), 32'(ex_y));
                reqs_total++;
                ex_x++;
                if (ex_x == H) begin
                    ex_x = 0;
                    ex_y = (ex_y + 1) % V;
                end
            end
            if (m_tvalid && m_tready) begin
                xb = bidx % H;
                yb = bidx / H;
                check_val("tdata", 32'(m_tdata),
                          32'({xb[3:0], xb[3:0], yb[3:0], yb[3:0], 8'hAA}));
                check_val("tuser", 32'(m_tuser), 32'(bidx == 0));
                check_val("tlast", 32'(m_tlast), 32'(xb == H - 1));
                bidx = (bidx + 1) % N;
                fb++;
                beats_total++;
            end
            if (frame_done) begin
                check_val("frame_beats", 32'(fb), 32'(N));
                fb = 0;
            end
        end
    end

    task automatic check_reset_outputs(input string tag);
        check_val({tag, "_req_valid"}, 32'(req_valid), 32'd0);
        check_val({tag, "_req_x"}, 32'(req_x), 32'd0);
        check_val({tag, "_req_y"}, 32'(req_y), 32'd0);
        check_val({tag, "_tvalid"}, 32'(m_tvalid), 32'd0);
        check_val({tag, "_tdata"}, 32'(m_tdata), 32'd0);
        check_val({tag, "_tuser"}, 32'(m_tuser), 32'd0);
        check_val({tag, "_tlast"}, 32'(m_tlast), 32'd0);
        check_val({tag, "_busy"}, 32'(busy), 32'd0);
        check_val({tag, "_frame_done"}, 32'(frame_done), 32'd0);
        check_val({tag, "_frame_count"}, 32'(frame_count), 32'd0);
        check_val({tag, "_sync_miss"}, 32'(sync_miss), 32'd0);
    endtask

    task automatic pulse_sync();
        @(posedge pixel_clk); #1 frame_sync = 1'b1;
        @(posedge pixel_clk); #1 frame_sync = 1'b0;
    endtask

    // Index 0 is the falling edge where frame_sync is seen high.
    task automatic run_frame_timed(output int first_tv, output int done_at);
        first_tv = -1;
        done_at  = -1;
        @(posedge pixel_clk); #1 frame_sync = 1'b1;
        @(negedge pixel_clk);
        @(posedge pixel_clk); #1 frame_sync = 1'b0;
        for (int k = 1; k < 400 && done_at < 0; k++) begin
            @(negedge pixel_clk);
            if (m_tvalid && first_tv < 0) first_tv = k;
            if (frame_done) done_at = k;
        end
    endtask

    task automatic wait_done(input string tag);
        int seen;
        seen = 0;
        for (int k = 0; k < 3000 && seen == 0; k++) begin
            @(negedge pixel_clk);
            if (frame_done) seen = 1;
        end
        #2;
        check_val({tag, "_done_seen"}, 32'(seen), 32'd1);
    endtask

    initial begin
        int first_tv, done_at, beats_snap, reqs_snap;

        #2 reset_n = 1'b0;
        repeat (3) @(posedge pixel_clk);
        #1 check_reset_outputs("rst");
        @(posedge pixel_clk); #1 reset_n = 1'b1;

        // Contiguous frame with tready held high.
        enable = 1'b1;
        ready_mode = 0;
        repeat (3) @(posedge pixel_clk);
        run_frame_timed(first_tv, done_at);
        #2;
        check_val("first_tvalid_lat", 32'(first_tv), 32'd3);
        check_val("done_lat", 32'(done_at), 32'(N + 3));
        check_val("busy_after_done", 32'(busy), 32'd0);
        check_val("frame_count_1", 32'(frame_count), 32'd1);
        check_val("sync_miss_clear", 32'(sync_miss), 32'd0);
        check_val("beats_f1", 32'(beats_total), 32'(N));

        // Random backpressure, with a stray sync in the middle of the frame.
        ready_mode = 1;
        repeat (2) @(posedge pixel_clk);
        pulse_sync();
        repeat (10) @(posedge pixel_clk);
        #1;
        check_val("busy_mid", 32'(busy), 32'd1);
        pulse_sync();
        wait_done("f2");
        check_val("sync_miss_set", 32'(sync_miss), 32'd1);
        check_val("frame_count_2", 32'(frame_count), 32'd2);
        repeat (2) @(posedge pixel_clk);
        pulse_sync();
        wait_done("f3");
        check_val("frame_count_3", 32'(frame_count), 32'd3);
        check_val("beats_f3", 32'(beats_total), 32'(3 * N));

        // enable dropped mid-frame: frame finishes, then further syncs are ignored.
        ready_mode = 0;
        repeat (2) @(posedge pixel_clk);
        pulse_sync();
        repeat (10) @(posedge pixel_clk);
        #1 enable = 1'b0;
        wait_done("f4");
        check_val("frame_count_4", 32'(frame_count), 32'd4);
        repeat (3) @(negedge pixel_clk);
        #2;
        beats_snap = beats_total;
        reqs_snap  = reqs_total;
        check_val("busy_idle", 32'(busy), 32'd0);
        pulse_sync();
        repeat (40) @(negedge pixel_clk);
        #2;
        check_val("idle_no_beats", 32'(beats_total), 32'(beats_snap));
        check_val("idle_no_reqs", 32'(reqs_total), 32'(reqs_snap));
        check_val("idle_count", 32'(frame_count), 32'd4);
        check_val("idle_busy", 32'(busy), 32'd0);

        // Reset in the middle of a stalled frame, then a clean frame.
        enable = 1'b1;
        ready_mode = 2;
        repeat (3) @(posedge pixel_clk);
        pulse_sync();
        repeat (8) @(posedge pixel_clk);
        #1 reset_n = 1'b0;
        #1 check_reset_outputs("midrst");
        @(negedge pixel_clk);
        #1 check_reset_outputs("midrst_hold");
        @(posedge pixel_clk); #1 reset_n = 1'b1;
        ready_mode = 0;
        repeat (3) @(posedge pixel_clk);
        run_frame_timed(first_tv, done_at);
        #2;
        check_val("post_rst_first_lat", 32'(first_tv), 32'd3);
        check_val("post_rst_done_lat", 32'(done_at), 32'(N + 3));
        check_val("post_rst_count", 32'(frame_count), 32'd1);

        repeat (4) @(posedge pixel_clk);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
